bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of requesting memory-bus masters (legal 1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, read/write data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles to wait for a slave response; 0 disables the timeout.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 m_memory_read  in  NUM_MASTERS  per-master read request.
REQ-008 m_memory_write  in  NUM_MASTERS  per-master write request.
REQ-009 m_option  in  3*NUM_MASTERS  per-master funct3 size/sign code.
REQ-010 m_address  in  ADDR_WIDTH*NUM_MASTERS  per-master address.
REQ-011 m_write_data  in  DATA_WIDTH*NUM_MASTERS  per-master store data.
REQ-012 m_memory_response  out  NUM_MASTERS  one-cycle completion pulse, one bit per master.
REQ-013 m_error  out  NUM_MASTERS  one-cycle timeout pulse, coincident with m_memory_response.
REQ-014 m_read_data  out  DATA_WIDTH  read data, shared by all masters and valid while any m_memory_response bit is high.
REQ-015 s_memory_read, s_memory_write  out  1 each  request to the slave memory.
REQ-016 s_option  out  3; s_address  out  ADDR_WIDTH; s_write_data  out  DATA_WIDTH  latched request fields.
REQ-017 s_memory_response  in  1; s_read_data  in  DATA_WIDTH  slave completion and read data.
REQ-018 grant_valid  out  1; grant_id  out  $clog2(NUM_MASTERS) (minimum 1)  current owner, for debug.

Function
REQ-019 Master i requests when m_memory_read[i] or m_memory_write[i] is high; it holds the request and all fields stable until it sees m_memory_response[i], and drops the request in the following cycle.
REQ-020 FSM states: IDLE, BUSY, RESP.
REQ-021 IDLE: at a clock edge with at least one request, the block picks a winner by round-robin, searching from last_grant+1 upward with wrap-around. It latches the winner's read, write, option, address and write_data, sets grant_id, and enters BUSY.
REQ-022 s_memory_read and s_memory_write SHALL be registered: asserted from the first BUSY cycle, which is 1 cycle after the request is sampled.
REQ-023 BUSY: on s_memory_response=1, the block registers s_read_data into m_read_data, deasserts s_memory_read/s_memory_write, and enters RESP.
REQ-024 RESP: lasts exactly one cycle; m_memory_response[grant_id] is high for that cycle and all other bits are low. At the end of RESP, last_grant<=grant_id and the state returns to IDLE; there is no back-to-back grant without an IDLE cycle.
REQ-025 Timeout (when TIMEOUT_CYCLES>0): a counter clears on entry to BUSY and increments each BUSY cycle. When the count reaches TIMEOUT_CYCLES with no response, the block enters RESP with m_read_data=0 and m_error[grant_id]=1.
REQ-026 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); the counter saturates and never wraps.
REQ-027 A response arriving in the same cycle as the timeout terminal count SHALL win: data is taken and no error is flagged.
REQ-028 s_memory_response SHALL be ignored in IDLE and RESP.
REQ-029 Once latched, a transaction is sticky: a master dropping its request mid-BUSY does not abort it.
REQ-030 Requests arriving during BUSY or RESP wait for the next IDLE evaluation.
REQ-031 A simultaneous read and write from one master SHALL be forwarded as a write only.
REQ-032 grant_valid SHALL be high in BUSY and RESP.
REQ-033 s_write_data and s_option SHALL pass unchanged; the block does not modify them.

Reset
REQ-034 Reset asserted at any time, including mid-BUSY, SHALL immediately force: state IDLE, all outputs 0, counter 0, and last_grant=NUM_MASTERS-1, so master 0 has first priority after reset.
REQ-035 A transaction aborted by reset SHALL produce no response pulse.

Structure
REQ-036 The FSM state encoding and the option codes (LB/LH/LW/LBU/LHU) SHALL live in the shared core package.
REQ-037 Round-robin selection SHALL be one combinational sub-module, rr_priority_select (inputs: request vector, last_grant; outputs: winner index, any).

Verification
REQ-038 Single master, N=2: m0 reads 0x100; the slave responds 3 cycles after s_memory_read with 0xDEADBEEF -> s_memory_read rises 1 cycle after the request, and m_memory_response[0] pulses for 1 cycle with m_read_data=0xDEADBEEF.
REQ-039 Contention: m0 and m1 both request on the cycle after reset -> m0 is granted first, then m1; with both held continuously, grants alternate 0,1,0,1.
REQ-040 Timeout: TIMEOUT_CYCLES=4 and the slave stays silent -> m_error[g] and m_memory_response[g] pulse together after 4 BUSY cycles, with m_read_data=0.
REQ-041 Race: s_memory_response arrives on the terminal-count cycle -> data is returned and m_error stays 0.
REQ-042 Reset mid-BUSY -> all outputs drop to 0 asynchronously; no response pulse follows; the next grant goes to m0.
REQ-043 N=4, m2 writes 0x55 to 0x20 with option 3'b000 -> s_memory_write=1, s_address=0x20, s_write_data=0x55, s_option=000, and grant_id=2.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter: FSM encoding and funct3 load/store size codes.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OPT_LB  = 3'b000;
  localparam logic [2:0] OPT_LH  = 3'b001;
  localparam logic [2:0] OPT_LW  = 3'b010;
  localparam logic [2:0] OPT_LBU = 3'b100;
  localparam logic [2:0] OPT_LHU = 3'b101;

endpackage

// File: rtl/bus_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first requester at or after last_grant+1, wrapping.
module rr_priority_select #(
  parameter int N  = 2,
  parameter int GW = 1
)(
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic [GW-1:0] winner,
  output logic          any
);

  // Walk offsets from farthest to nearest so the nearest hit after last_grant wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int k = N; k >= 1; k--) begin
      for (int j = 0; j < N; j++) begin
        if (req[j] && ((j == int'(last_grant) + k) || (j + N == int'(last_grant) + k))) begin
          winner = GW'(j);
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter funnelling NUM_MASTERS memory masters onto one slave port,
// with an optional response timeout that completes the transaction with an error pulse.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
)(
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_memory_read,
  input  logic [NUM_MASTERS-1:0]            m_memory_write,
  input  logic [3*NUM_MASTERS-1:0]          m_option,
  input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] m_address,
  input  logic [DATA_WIDTH*NUM_MASTERS-1:0] m_write_data,
  output logic [NUM_MASTERS-1:0]            m_memory_response,
  output logic [NUM_MASTERS-1:0]            m_error,
  output logic [DATA_WIDTH-1:0]             m_read_data,
  output logic                              s_memory_read,
  output logic                              s_memory_write,
  output logic [2:0]                        s_option,
  output logic [ADDR_WIDTH-1:0]             s_address,
  output logic [DATA_WIDTH-1:0]             s_write_data,
  input  logic                              s_memory_response,
  input  logic [DATA_WIDTH-1:0]             s_read_data,
  output logic                              grant_valid,
  output logic [GW-1:0]                     grant_id
);

  localparam int            CW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TERM = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

  state_t                 state;
  logic [GW-1:0]          last_grant, winner;
  logic                   any;
  logic [CW-1:0]          cnt;
  logic [NUM_MASTERS-1:0] req, grant_oh;
  logic                   sel_rd, sel_wr, timeout;
  logic [2:0]             sel_opt;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  assign req = m_memory_read | m_memory_write;

  rr_priority_select #(.N(NUM_MASTERS), .GW(GW)) u_sel (
    .req        (req),
    .last_grant (last_grant),
    .winner     (winner),
    .any        (any)
  );

  always_comb begin
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_opt   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    grant_oh  = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (GW'(j) == winner) begin
        sel_rd    = m_memory_read[j];
        sel_wr    = m_memory_write[j];
        sel_opt   = m_option[3*j +: 3];
        sel_addr  = m_address[ADDR_WIDTH*j +: ADDR_WIDTH];
        sel_wdata = m_write_data[DATA_WIDTH*j +: DATA_WIDTH];
      end
      grant_oh[j] = (GW'(j) == grant_id);
    end
  end

  // Terminal count falls on the TIMEOUT_CYCLES-th BUSY cycle; a response then still wins.
  assign timeout = (TIMEOUT_CYCLES > 0) && (cnt == TERM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      last_grant        <= GW'(NUM_MASTERS - 1);
      cnt               <= '0;
      grant_valid       <= 1'b0;
      grant_id          <= '0;
      s_memory_read     <= 1'b0;
      s_memory_write    <= 1'b0;
      s_option          <= '0;
      s_address         <= '0;
      s_write_data      <= '0;
      m_memory_response <= '0;
      m_error           <= '0;
      m_read_data       <= '0;
    end else begin
      m_memory_response <= '0;
      m_error           <= '0;
      unique case (state)
        ST_IDLE: if (any) begin
          grant_id       <= winner;
          grant_valid    <= 1'b1;
          s_memory_write <= sel_wr;
          s_memory_read  <= sel_rd & ~sel_wr;
          s_option       <= sel_opt;
          s_address      <= sel_addr;
          s_write_data   <= sel_wdata;
          cnt            <= '0;
          state          <= ST_BUSY;
        end
        ST_BUSY: begin
          if (s_memory_response) begin
            m_read_data       <= s_read_data;
            m_memory_response <= grant_oh;
            s_memory_read     <= 1'b0;
            s_memory_write    <= 1'b0;
            state             <= ST_RESP;
          end else if (timeout) begin
            m_read_data       <= '0;
            m_memory_response <= grant_oh;
            m_error           <= grant_oh;
            s_memory_read     <= 1'b0;
            s_memory_write    <= 1'b0;
            state             <= ST_RESP;
          end else if (cnt != SAT) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          last_grant  <= grant_id;
          grant_valid <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized transaction-level bench for bus_arbiter (4 masters, 4-cycle timeout).
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int N = 4, DW = 32, AW = 32, TO = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    m_memory_read, m_memory_write;
  logic [3*N-1:0]  m_option;
  logic [AW*N-1:0] m_address;
  logic [DW*N-1:0] m_write_data;
  logic [N-1:0]    m_memory_response, m_error;
  logic [DW-1:0]   m_read_data;
  logic            s_memory_read, s_memory_write;
  logic [2:0]      s_option;
  logic [AW-1:0]   s_address;
  logic [DW-1:0]   s_write_data;
  logic            s_memory_response;
  logic [DW-1:0]   s_read_data;
  logic            grant_valid;
  logic [1:0]      grant_id;

  int checks = 0, errors = 0;

  // Reference state: who is holding a request, their fields, and the last owner.
  logic [N-1:0] pend;
  bit           p_rd [N];
  bit           p_wr [N];
  logic [2:0]   p_opt [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_wd [N];
  int           last_g;
  logic [2:0]   opts [5] = '{OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU};

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m_memory_read(m_memory_read), .m_memory_write(m_memory_write),
    .m_option(m_option), .m_address(m_address), .m_write_data(m_write_data),
    .m_memory_response(m_memory_response), .m_error(m_error), .m_read_data(m_read_data),
    .s_memory_read(s_memory_read), .s_memory_write(s_memory_write),
    .s_option(s_option), .s_address(s_address), .s_write_data(s_write_data),
    .s_memory_response(s_memory_response), .s_read_data(s_read_data),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      m_memory_read[i]         = pend[i] & p_rd[i];
      m_memory_write[i]        = pend[i] & p_wr[i];
      m_option[3*i +: 3]       = p_opt[i];
      m_address[AW*i +: AW]    = p_addr[i];
      m_write_data[DW*i +: DW] = p_wd[i];
    end
  endtask

  task automatic new_req(input int i);
    int r;
    r         = $urandom_range(0, 2);
    pend[i]   = 1'b1;
    p_rd[i]   = (r != 1);
    p_wr[i]   = (r != 0);
    p_opt[i]  = opts[$urandom_range(0, 4)];
    p_addr[i] = $urandom;
    p_wd[i]   = $urandom;
  endtask

  task automatic add_random(input int excl);
    int c[$];
    for (int i = 0; i < N; i++) if (!pend[i] && i != excl) c.push_back(i);
    if (c.size() > 0) new_req(c[$urandom_range(0, c.size() - 1)]);
  endtask

  // One full grant: entered at an IDLE cycle with requests driven; leaves in the next IDLE cycle.
  // lat = BUSY cycle in which the slave answers; lat > TO means the slave stays silent.
  task automatic txn(input int lat, input bit rnd, input bit readd, input bit use_fix,
                     input logic [DW-1:0] fix);
    int w;
    logic [DW-1:0] rdata;
    logic [N-1:0]  oh;
    w  = rr_pick(pend, last_g);
    oh = N'(1) << w;
    @(posedge clk); #1;
    chk("grant_valid", grant_valid, 1);
    chk("grant_id", grant_id, w);
    chk("s_read", s_memory_read, p_rd[w] & ~p_wr[w]);
    chk("s_write", s_memory_write, p_wr[w]);
    chk("s_address", s_address, p_addr[w]);
    chk("s_write_data", s_write_data, p_wd[w]);
    chk("s_option", s_option, p_opt[w]);
    for (int k = 1; k <= TO; k++) begin
      if (rnd && $urandom_range(0, 3) == 0) add_random(w);
      if (rnd && $urandom_range(0, 7) == 0) pend[w] = 1'b0;
      rdata             = use_fix ? fix : DW'($urandom);
      s_read_data       = rdata;
      s_memory_response = (k == lat);
      drive();
      @(posedge clk); #1;
      s_memory_response = 1'b0;
      if (k == lat || k == TO) begin
        chk("resp_pulse", m_memory_response, oh);
        chk("resp_error", m_error, (k == lat) ? '0 : oh);
        chk("resp_data", m_read_data, (k == lat) ? rdata : '0);
        chk("resp_sreq_off", s_memory_read | s_memory_write, 0);
        chk("resp_gv", grant_valid, 1);
        break;
      end
      chk("busy_no_resp", m_memory_response | m_error, 0);
      chk("busy_sreq", s_memory_read | s_memory_write, 1);
    end
    s_memory_response = 1'($urandom_range(0, 1));
    s_read_data       = $urandom;
    @(posedge clk); #1;
    s_memory_response = 1'b0;
    chk("idle_gv", grant_valid, 0);
    chk("idle_no_resp", m_memory_response | m_error, 0);
    last_g = w;
    pend[w] = 1'b0;
    if (readd) new_req(w);
    drive();
  endtask

  initial begin
    reset = 1'b1;
    s_memory_response = 1'b0;
    s_read_data = '0;
    pend = '0;
    for (int i = 0; i < N; i++) begin
      p_rd[i] = 0; p_wr[i] = 0; p_opt[i] = '0; p_addr[i] = '0; p_wd[i] = '0;
    end
    drive();
    last_g = N - 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_resp", {m_memory_response, m_error}, 0);
    chk("rst_rdata", m_read_data, 0);
    chk("rst_sreq", {s_memory_read, s_memory_write, s_option}, 0);
    chk("rst_saddr", s_address, 0);
    chk("rst_swdata", s_write_data, 0);
    chk("rst_grant", {grant_valid, grant_id}, 0);
    reset = 1'b0;

    // Contention right after reset: m0 then m1, alternating while both keep asking.
    new_req(0); new_req(1); drive();
    for (int i = 0; i < 4; i++) txn($urandom_range(1, 3), 0, 1, 0, '0);
    pend = '0; drive();

    // Single read of 0x100 answered three cycles into BUSY.
    new_req(0); p_rd[0] = 1; p_wr[0] = 0; p_addr[0] = 'h100; p_opt[0] = OPT_LW; drive();
    txn(3, 0, 0, 1, 32'hDEADBEEF);

    // Write 0x55 to 0x20 from master 2.
    new_req(2); p_rd[2] = 0; p_wr[2] = 1; p_addr[2] = 'h20; p_wd[2] = 'h55; p_opt[2] = OPT_LB; drive();
    txn(2, 0, 0, 0, '0);

    // Silent slave -> timeout; then a response exactly on the terminal count.
    new_req(3); drive(); txn(TO + 1, 0, 0, 0, '0);
    new_req(1); drive(); txn(TO, 0, 0, 0, '0);

    // Randomized traffic with late arrivals, mid-BUSY drops and idle gaps.
    for (int n = 0; n < 80; n++) begin
      if (pend == '0) begin
        s_memory_response = 1'b1;
        @(posedge clk); #1;
        s_memory_response = 1'b0;
        chk("idle_ignore_resp", m_memory_response | m_error, 0);
        chk("idle_no_grant", grant_valid, 0);
        add_random(-1);
      end
      if ($urandom_range(0, 1) == 0) add_random(-1);
      drive();
      txn($urandom_range(1, TO + 1), 1, 0, 0, '0);
    end

    // Reset in the middle of BUSY.
    pend = '0;
    new_req(1); new_req(3); drive();
    @(posedge clk); #1;
    chk("pre_rst_busy", grant_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_sreq", {s_memory_read, s_memory_write}, 0);
    chk("async_rst_grant", {grant_valid, grant_id}, 0);
    chk("async_rst_resp", {m_memory_response, m_error}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    pend = '0; drive();
    last_g = N - 1;
    for (int i = 0; i < 3; i++) begin
      s_memory_response = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_no_resp", m_memory_response | m_error, 0);
      chk("post_rst_no_grant", grant_valid, 0);
    end
    s_memory_response = 1'b0;
    new_req(0); new_req(2); new_req(3); drive();
    txn(2, 0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
